// File: rtl/pipeline.sv
// Shared pipeline parameters for the front-end stages.
package pipeline;
  parameter int XLEN = 32;
endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of DEPTH entries (instr[31:2], pc, pc+4).
// Latency 1 cycle; `define FETCH_QUEUE_BYPASS_EN adds a zero-latency path when empty.
// Backpressure: in_ready = !full (independent of out_ready); flush drops everything, incl. the cycle's push/pop.
module fetch_queue
  import pipeline::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:2]              in_instr,
  input  logic [XLEN-1:0]          in_curr_pc,
  input  logic [XLEN-1:0]          in_inc_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:2]              out_instr,
  output logic [XLEN-1:0]          out_curr_pc,
  output logic [XLEN-1:0]          out_inc_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two in 2..16");
  end

  logic [29:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] curr_mem  [DEPTH];
  logic [XLEN-1:0] inc_mem   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          bypass;
  logic          stored_valid;
  logic          push;
  logic          pop;

  assign in_ready     = (count != FULL);
  assign stored_valid = (count != '0) && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue hands the incoming entry straight to decode without storing it.
  assign bypass      = (count == '0) && in_valid && out_ready && !flush;
  assign out_valid   = stored_valid || bypass;
  assign out_instr   = bypass ? in_instr   : instr_mem[rd_ptr];
  assign out_curr_pc = bypass ? in_curr_pc : curr_mem[rd_ptr];
  assign out_inc_pc  = bypass ? in_inc_pc  : inc_mem[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign out_valid   = stored_valid;
  assign out_instr   = instr_mem[rd_ptr];
  assign out_curr_pc = curr_mem[rd_ptr];
  assign out_inc_pc  = inc_mem[rd_ptr];
`endif

  // in_ready already excludes full, so a same-cycle pop never frees room for a push.
  assign push = in_valid && in_ready && !flush && !bypass;
  assign pop  = stored_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      curr_mem[wr_ptr]  <= in_curr_pc;
      inc_mem[wr_ptr]   <= in_inc_pc;
    end
  end

  always @(posedge clk) begin
    if (!reset) assert (!(count > FULL));
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;
  import pipeline::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:2]     in_instr;
  logic [XLEN-1:0] in_curr_pc;
  logic [XLEN-1:0] in_inc_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:2]     out_instr;
  logic [XLEN-1:0] out_curr_pc;
  logic [XLEN-1:0] out_inc_pc;
  logic [2:0]      count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_curr_pc(in_curr_pc), .in_inc_pc(in_inc_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_curr_pc(out_curr_pc), .out_inc_pc(out_inc_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:2] ins(input logic [XLEN-1:0] pc);
    logic [29:0] key;
    key = 30'h15555555;
    return pc[29:0] ^ key;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [XLEN-1:0] pc, input logic ordy, input logic fl);
    in_valid   = iv;
    in_curr_pc = pc;
    in_inc_pc  = pc + 4;
    in_instr   = ins(pc);
    out_ready  = ordy;
    flush      = fl;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    reset = 1'b0;

    // Fill with PCs 0x0..0xC, decode stalled.
    drive(1'b1, 32'h0, 1'b0, 1'b0);
    tick();
    chk("lat1_out_valid", 64'(out_valid), 64'd1);
    chk("lat1_count", 64'(count), 64'd1);
    drive(1'b1, 32'h4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h8, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    tick();
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_pc", 64'(out_curr_pc), 64'h0);
    chk("full_head_inc", 64'(out_inc_pc), 64'h4);
    chk("full_head_instr", 64'(out_instr), 64'(ins(32'h0)));
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    tick();
    chk("refused_count", 64'(count), 64'd4);

    // Full with simultaneous push attempt and pop: pop only.
    drive(1'b1, 32'h10, 1'b1, 1'b0);
    tick();
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_head_pc", 64'(out_curr_pc), 64'h4);
    chk("fullpop_in_ready", 64'(in_ready), 64'd1);

    // Drop to two entries (0x8, 0xC), then stream 10 cycles of push+pop.
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("pop_to2_count", 64'(count), 64'd2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h10 + 32'(4 * k), 1'b1, 1'b0);
      #1;
      chk($sformatf("stream_head_pc_%0d", k), 64'(out_curr_pc), 64'(32'h8 + 32'(4 * k)));
      chk($sformatf("stream_head_instr_%0d", k), 64'(out_instr), 64'(ins(32'h8 + 32'(4 * k))));
      tick();
    end
    chk("stream_count", 64'(count), 64'd2);
    chk("stream_end_head", 64'(out_curr_pc), 64'h30);

    drive(1'b1, 32'h38, 1'b0, 1'b0);
    tick();
    chk("pre_flush_count", 64'(count), 64'd3);

    // Flush with push and pop requested in the same cycle.
    drive(1'b1, 32'h3C, 1'b1, 1'b1);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("post_flush_count", 64'(count), 64'd0);
    chk("post_flush_out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    chk("after_flush_head", 64'(out_curr_pc), 64'h100);
    chk("after_flush_count", 64'(count), 64'd1);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("drain_count", 64'(count), 64'd0);

    // Empty queue, push with decode ready.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_out_pc", 64'(out_curr_pc), 64'h40);
    tick();
    chk("byp_count", 64'(count), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("byp_after_valid", 64'(out_valid), 64'd0);
`else
    chk("nobyp_out_valid", 64'(out_valid), 64'd0);
    tick();
    chk("nobyp_count", 64'(count), 64'd1);
    chk("nobyp_out_valid_next", 64'(out_valid), 64'd1);
    chk("nobyp_out_pc", 64'(out_curr_pc), 64'h40);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    chk("nobyp_drain", 64'(count), 64'd0);
`endif

    // Three entries, then reset between edges.
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h84, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("prereset_count", 64'(count), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0;
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("postreset_head", 64'(out_curr_pc), 64'h200);
    chk("postreset_count", 64'(count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the number of queue entries; the value SHALL be a power of two, 2..16.
REQ-002 The module SHALL take XLEN from package pipeline.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: redirect taken (jump enable from execute); discards all queued and incoming entries.
REQ-006 Port in_valid, input, 1 bit: the fetch stage presents an entry.
REQ-007 Port in_ready, output, 1 bit: the queue accepts an entry this cycle; this output drives the fetch stage's stall input, inverted.
REQ-008 Port in_instr, input, [31:2]: fetched instruction; bits [1:0] are implicitly 2'b11 and SHALL NOT be stored.
REQ-009 Port in_curr_pc, input, XLEN bits: PC of in_instr.
REQ-010 Port in_inc_pc, input, XLEN bits: PC+4 of in_instr.
REQ-011 Port out_valid, output, 1 bit: the head entry is available to decode.
REQ-012 Port out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-013 Ports out_instr [31:2], out_curr_pc and out_inc_pc (XLEN bits each), outputs: the head entry fields.
REQ-014 Port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-015 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-016 Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-017 in_ready SHALL equal (count != DEPTH).
- When full, push SHALL NOT occur even if a pop occurs in the same cycle.
- No combinational path SHALL exist from out_ready to in_ready.
REQ-018 out_valid SHALL equal (count != 0) && !flush, except as extended by REQ-026.
REQ-019 out_* fields SHALL be driven from the entry at the read pointer; their value is don't-care while out_valid=0.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 Order SHALL be strict FIFO; entries SHALL never be duplicated or reordered.
REQ-022 On flush:
- count, read pointer and write pointer SHALL return to 0 at the next edge;
- any push or pop in the flush cycle SHALL be discarded;
- in_ready SHALL follow REQ-017 unchanged.
REQ-023 Without bypass, minimum latency SHALL be 1 cycle: an entry pushed at edge N appears with out_valid at cycle N+1.
REQ-024 Pushing an entry while full, or popping while empty, SHALL be impossible by construction; the assertion (!(count > DEPTH)) SHALL hold.

Reset
REQ-025 While reset=1, the following SHALL be forced immediately and asynchronously: count=0, both pointers=0, out_valid=0, in_ready=1; entry storage contents are not reset. Reset asserted mid-stream SHALL discard all entries.

Configuration
REQ-026 Macro FETCH_QUEUE_BYPASS_EN:
- When defined, with count==0 && in_valid && out_ready && !flush:
  - out_valid SHALL be 1;
  - out_* SHALL equal in_* combinationally;
  - the entry SHALL NOT be written into storage, and count SHALL stay 0 (zero-latency path).
- When not defined, there SHALL be no input-to-output combinational path, and REQ-023 applies.

Verification
REQ-027 Reset, then push PC 0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0, out_curr_pc=0x0; a 5th push is refused.
REQ-028 Full queue, in_valid=1 and out_ready=1 for one cycle -> one pop, no push, count=3, out_curr_pc=0x4.
REQ-029 Count=2 with continuous push and pop for 10 cycles -> count stays 2, outputs in order, pointers wrap past DEPTH-1 correctly.
REQ-030 Count=3, flush=1 with in_valid=1 and out_ready=1 -> out_valid=0 in that cycle; count=0 next cycle; the next pushed PC 0x100 is the first output.
REQ-031 Empty queue, push PC 0x40 with out_ready=1 -> with FETCH_QUEUE_BYPASS_EN: out_valid same cycle, count stays 0; without it: out_valid next cycle, count=1.
REQ-032 Count=3, assert reset between edges -> count=0 and out_valid=0 before the next edge.
